// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_state_t;

  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_PLL_RST_CYC      = 32;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYC = 27000;
  localparam int DEF_MAX_RETRY        = 3;
  localparam int DEF_LOSS_CNT_W       = 8;

  // Width of a counter that must hold 0 .. limit-1; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level; all stages clear to 0 on reset.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL reset / lock-qualification sequencer on the crystal clock.
// Optional lock-loss counter and loss_cnt_o port exist only when PLL_SEQ_LOSS_CNT_EN is defined.
module pll_rst_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  parameter int LOSS_CNT_W       = DEF_LOSS_CNT_W
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock_i,
  input  logic       soft_rst_i,
  output logic       pll_reset_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fail_o,
`ifdef PLL_SEQ_LOSS_CNT_EN
  output logic [3:0] retry_cnt_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o
`else
  output logic [3:0] retry_cnt_o
`endif
);

  localparam int RW = cnt_w(PLL_RST_CYC);
  localparam int SW = cnt_w(LOCK_STABLE_CYC);
  localparam int TW = cnt_w(LOCK_TIMEOUT_CYC);

  localparam logic [RW-1:0] RST_LAST  = RW'(PLL_RST_CYC - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  pll_state_t    state;
  pll_state_t    state_next;
  logic [RW-1:0] rst_cnt;
  logic [RW-1:0] rst_cnt_next;
  logic [SW-1:0] stb_cnt;
  logic [SW-1:0] stb_cnt_next;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_cnt_next;
  logic [3:0]    retry;
  logic [3:0]    retry_next;

  logic lock_s;
  logic timeout;
  logic stable_done;
  logic pll_reset_d;
  logic sys_rst_d;
  logic ready_d;
  logic fail_d;

  cdc_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(clk),
    .rst(rst),
    .d  (pll_lock_i),
    .q  (lock_s)
  );

  // The timeout window spans WAIT_LOCK and STABLE; it restarts only on entry from PLL_RST or RUN.
  assign timeout     = (tmo_cnt == TMO_LAST);
  assign stable_done = lock_s && (stb_cnt == STB_LAST);

  // State and counter register; outputs are registered images of the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PLL_RST;
      rst_cnt     <= '0;
      stb_cnt     <= '0;
      tmo_cnt     <= '0;
      retry       <= '0;
      pll_reset_o <= 1'b1;
      sys_rst_o   <= 1'b1;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
      retry_cnt_o <= '0;
    end else begin
      state       <= state_next;
      rst_cnt     <= rst_cnt_next;
      stb_cnt     <= stb_cnt_next;
      tmo_cnt     <= tmo_cnt_next;
      retry       <= retry_next;
      pll_reset_o <= pll_reset_d;
      sys_rst_o   <= sys_rst_d;
      ready_o     <= ready_d;
      fail_o      <= fail_d;
      retry_cnt_o <= retry;
    end
  end

  // Next-state logic. Counters default to clear so each state only keeps what it uses.
  always_comb begin
    state_next   = state;
    rst_cnt_next = '0;
    stb_cnt_next = '0;
    tmo_cnt_next = '0;
    retry_next   = retry;
    if (soft_rst_i) begin
      state_next = PLL_RST;
      retry_next = '0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (rst_cnt == RST_LAST) begin
            state_next = WAIT_LOCK;
          end else begin
            rst_cnt_next = rst_cnt + RW'(1);
          end
        end
        WAIT_LOCK, STABLE: begin
          // Timeout beats every lock event except a completed stability run.
          if (timeout && !((state == STABLE) && stable_done)) begin
            if (retry == RETRY_MAX) begin
              state_next = FAIL;
            end else begin
              state_next = PLL_RST;
              retry_next = retry + 4'd1;
            end
          end else if (!lock_s) begin
            state_next   = WAIT_LOCK;
            tmo_cnt_next = tmo_cnt + TW'(1);
          end else if (state == WAIT_LOCK) begin
            state_next   = STABLE;
            tmo_cnt_next = tmo_cnt + TW'(1);
          end else if (stable_done) begin
            state_next = RUN;
            retry_next = '0;
          end else begin
            stb_cnt_next = stb_cnt + SW'(1);
            tmo_cnt_next = tmo_cnt + TW'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
          end
        end
        FAIL: begin
          state_next = FAIL;
        end
        default: begin
          state_next = PLL_RST;
        end
      endcase
    end
  end

  // Output decode from the current state; registered above.
  always_comb begin
    pll_reset_d = (state == PLL_RST);
    sys_rst_d   = (state != RUN);
    ready_d     = (state == RUN);
    fail_d      = (state == FAIL);
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic                  lock_lost;
  logic [LOSS_CNT_W-1:0] loss;

  assign lock_lost = (state == RUN) && !lock_s && !soft_rst_i;

  // Saturating lock-loss event count; survives soft restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      loss       <= '0;
      loss_cnt_o <= '0;
    end else begin
      if (lock_lost && !(&loss)) begin
        loss <= loss + LOSS_CNT_W'(1);
      end
      loss_cnt_o <= loss;
    end
  end
`endif

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Directed + randomized bench for pll_rst_sequencer against a cycle-level behavioural model.
module tb_pll_rst_sequencer;

  localparam int SYNC = 2;
  localparam int PRC  = 4;
  localparam int LSC  = 8;
  localparam int TMO  = 50;
  localparam int MAXR = 2;
  localparam int LW   = 2;
  localparam int LOSS_MAX = (1 << LW) - 1;

  logic       clk;
  logic       rst;
  logic       pll_lock_i;
  logic       soft_rst_i;
  logic       pll_reset_o;
  logic       sys_rst_o;
  logic       ready_o;
  logic       fail_o;
  logic [3:0] retry_cnt_o;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LW-1:0] loss_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pll_rst_sequencer #(
    .SYNC_STAGES     (SYNC),
    .PLL_RST_CYC     (PRC),
    .LOCK_STABLE_CYC (LSC),
    .LOCK_TIMEOUT_CYC(TMO),
    .MAX_RETRY       (MAXR)
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    .LOSS_CNT_W      (LW)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock_i (pll_lock_i),
    .soft_rst_i (soft_rst_i),
    .pll_reset_o(pll_reset_o),
    .sys_rst_o  (sys_rst_o),
    .ready_o    (ready_o),
    .fail_o     (fail_o),
`ifdef PLL_SEQ_LOSS_CNT_EN
    .retry_cnt_o(retry_cnt_o),
    .loss_cnt_o (loss_cnt_o)
`else
    .retry_cnt_o(retry_cnt_o)
`endif
  );

  // ---------------- behavioural reference ----------------
  // mode: 0 = PLL held in reset, 1 = acquiring lock, 2 = running, 3 = failed
  int   m_mode, m_age, m_streak, m_retry, m_loss;
  logic m_sh [SYNC];
  logic e_pll, e_sys, e_rdy, e_fail;
  int   e_retry, e_loss;

  task automatic model_step(input logic rs, input logic sr, input logic lk);
    logic ls;
    if (rs) begin
      m_mode = 0; m_age = 0; m_streak = 0; m_retry = 0; m_loss = 0;
      for (int i = 0; i < SYNC; i++) m_sh[i] = 1'b0;
      e_pll = 1'b1; e_sys = 1'b1; e_rdy = 1'b0; e_fail = 1'b0; e_retry = 0; e_loss = 0;
      return;
    end
    // Registered outputs show the condition held before this edge.
    e_pll   = (m_mode == 0);
    e_sys   = (m_mode != 2);
    e_rdy   = (m_mode == 2);
    e_fail  = (m_mode == 3);
    e_retry = m_retry;
    e_loss  = m_loss;
    ls = m_sh[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = lk;
    if (sr) begin
      m_mode = 0; m_age = 0; m_retry = 0;
    end else begin
      case (m_mode)
        0: begin
          m_age++;
          if (m_age == PRC) begin m_mode = 1; m_age = 0; m_streak = 0; end
        end
        1: begin
          // Release needs one edge to see lock plus LSC further consecutive lock edges.
          m_age++;
          m_streak = ls ? m_streak + 1 : 0;
          if (m_streak == LSC + 1) begin
            m_mode = 2; m_retry = 0;
          end else if (m_age == TMO) begin
            if (m_retry < MAXR) begin m_retry++; m_mode = 0; m_age = 0; end
            else m_mode = 3;
          end
        end
        2: begin
          if (!ls) begin
            m_mode = 1; m_age = 0; m_streak = 0;
            if (m_loss < LOSS_MAX) m_loss++;
          end
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("pll_reset_o", 32'(pll_reset_o), 32'(e_pll));
    chk("sys_rst_o", 32'(sys_rst_o), 32'(e_sys));
    chk("ready_o", 32'(ready_o), 32'(e_rdy));
    chk("fail_o", 32'(fail_o), 32'(e_fail));
    chk("retry_cnt_o", 32'(retry_cnt_o), 32'(e_retry));
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("loss_cnt_o", 32'(loss_cnt_o), 32'(e_loss));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic lk, input logic sr, input logic rs);
    pll_lock_i = lk;
    soft_rst_i = sr;
    rst        = rs;
    @(posedge clk);
    model_step(rs, sr, lk);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int n, input logic lk);
    for (int i = 0; i < n; i++) cycle(lk, 1'b0, 1'b1);
  endtask

  // Edges until sys_rst_o reaches target; expiry of the bound surfaces as a count mismatch.
  task automatic wait_sys(input logic target, input logic lk, output int n);
    n = 0;
    while (sys_rst_o !== target && n < 200) begin
      cycle(lk, 1'b0, 1'b0);
      n++;
    end
  endtask

  int   n, pulses, high_cyc, ready_seen;
  logic prev, lk;
  int   hold;

  initial begin
    rst = 1'b1; pll_lock_i = 1'b0; soft_rst_i = 1'b0;
    m_mode = 0; m_age = 0; m_streak = 0; m_retry = 0; m_loss = 0;
    for (int i = 0; i < SYNC; i++) m_sh[i] = 1'b0;

    // 1. Reset with lock tied high: 4-cycle PLL pulse, then release.
    do_reset(3, 1'b1);
    chk("rst_pll_reset", 32'(pll_reset_o), 32'd1);
    chk("rst_sys_rst", 32'(sys_rst_o), 32'd1);
    chk("rst_retry", 32'(retry_cnt_o), 32'd0);
    high_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (pll_reset_o) high_cyc++;
    end
    chk("pll_pulse_width", 32'(high_cyc), 32'(PRC));
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("first_release_ready", 32'(ready_o), 32'd1);

    // 2. One-cycle lock drop while running.
    cycle(1'b0, 1'b0, 1'b0);
    wait_sys(1'b1, 1'b1, n);
    chk("loss_latency", 32'(n), 32'd3);
    // Lock returned on the edge after the drop; two of its edges are already behind us.
    wait_sys(1'b0, 1'b1, n);
    chk("relock_latency", 32'(n), 32'(SYNC + LSC + 1 - 2));
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("loss_count_one", 32'(loss_cnt_o), 32'd1);
`endif

    // Lock rising mid-WAIT_LOCK: release SYNC+LSC+1 edges after first sampling edge.
    do_reset(2, 1'b0);
    for (int i = 0; i < PRC + 6; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    wait_sys(1'b0, 1'b1, n);
    chk("release_latency", 32'(n), 32'(SYNC + LSC + 1));

    // 3. Lock never asserts: three PLL pulses, then sticky failure.
    do_reset(2, 1'b0);
    pulses = 0; high_cyc = 0; prev = 1'b0;
    for (int i = 0; i < 180; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (pll_reset_o && !prev) pulses++;
      if (pll_reset_o) high_cyc++;
      prev = pll_reset_o;
    end
    chk("nolock_pulses", 32'(pulses), 32'(MAXR + 1));
    chk("nolock_high_cycles", 32'(high_cyc), 32'((MAXR + 1) * PRC));
    chk("nolock_fail", 32'(fail_o), 32'd1);
    chk("nolock_retry", 32'(retry_cnt_o), 32'(MAXR));
    chk("nolock_sys_rst", 32'(sys_rst_o), 32'd1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("fail_sticky", 32'(fail_o), 32'd1);
    chk("fail_pll_reset_low", 32'(pll_reset_o), 32'd0);

    // 4. Soft restart out of FAIL with lock present.
    cycle(1'b1, 1'b1, 1'b0);
    high_cyc = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (pll_reset_o) high_cyc++;
    end
    chk("soft_pulse_width", 32'(high_cyc), 32'(PRC));
    chk("soft_fail_cleared", 32'(fail_o), 32'd0);
    chk("soft_released", 32'(sys_rst_o), 32'd0);

    // 5. Lock toggling every 5 cycles never qualifies; timeouts still retire the PLL.
    do_reset(2, 1'b0);
    ready_seen = 0; pulses = 0; prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle(((i / 5) % 2) == 0, 1'b0, 1'b0);
      if (ready_o) ready_seen++;
      if (pll_reset_o && !prev) pulses++;
      prev = pll_reset_o;
    end
    chk("toggle_never_run", 32'(ready_seen), 32'd0);
    chk("toggle_pulses", 32'(pulses), 32'(MAXR + 1));
    chk("toggle_fail", 32'(fail_o), 32'd1);

    // 6. rst together with soft_rst_i while in STABLE after a loss.
    do_reset(2, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("rst_soft_pll_reset", 32'(pll_reset_o), 32'd1);
    chk("rst_soft_sys_rst", 32'(sys_rst_o), 32'd1);
    chk("rst_soft_ready", 32'(ready_o), 32'd0);
    chk("rst_soft_fail", 32'(fail_o), 32'd0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("rst_soft_loss", 32'(loss_cnt_o), 32'd0);
`endif

    // 7. Randomized lock behaviour with occasional soft and hard resets.
    do_reset(2, 1'b0);
    lk = 1'b1; hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        lk = ($urandom_range(0, 9) < 7);
        if (lk) hold = $urandom_range(1, 30);
        else hold = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 80 : 4);
      end
      hold--;
      cycle(lk, $urandom_range(0, 199) == 0, $urandom_range(0, 799) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
